// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// requester IDs, RW polarity and the default fetch opcode.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_MOC = 3'd2,
        ST_DONE     = 3'd3,
        ST_RELEASE  = 3'd4
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // lw opcode: fetches are always full-word reads
    localparam logic [5:0] IF_OPC_DEFAULT = 6'b100011;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between fetch and data requesters.
// Purely combinational; the last-grant register lives in the parent.
//   if_req, d_req : request levels
//   last_grant    : requester served most recently
//   valid_c       : at least one request present
//   grant_c       : requester to serve next
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
    input  req_id_t last_grant,
    output logic    valid_c,
    output req_id_t grant_c
);

    always_comb begin
        valid_c = if_req | d_req;
        grant_c = REQ_IF;
        if (if_req && d_req) begin
            // tie: serve whoever did not go last
            grant_c = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
        end else if (d_req) begin
            grant_c = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM MOV/MOC/RW port between instruction fetch and
// load/store. One outstanding transaction at a time, round-robin on ties.
// Ports:
//   clk, reset            : clock, async active-low reset
//   if_req/if_addr        : fetch request; if_rdata/if_done return
//   d_req/d_rw/d_addr/d_wdata/d_opc : data request; d_rdata/d_done return
//   mem_mov/mem_rw/mem_addr/mem_wdata/mem_opc : RAM command
//   mem_rdata/mem_moc     : RAM response
//   busy                  : arbiter not idle
//   err                   : sticky MOC timeout (only with MEM_TIMEOUT_EN)
// Build option: define MEM_TIMEOUT_EN to add the MOC watchdog and err port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned     ADDR_W         = 9,
    parameter int unsigned     DATA_W         = 32,
    parameter int unsigned     OPC_W          = 6,
    parameter logic [OPC_W-1:0] IF_OPC        = OPC_W'(IF_OPC_DEFAULT),
    parameter int unsigned     TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_rw,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [OPC_W-1:0]  d_opc,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_mov,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [OPC_W-1:0]  mem_opc,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_moc,
`ifdef MEM_TIMEOUT_EN
    output logic              busy,
    output logic              err
`else
    output logic              busy
`endif
);

    // reject a zero watchdog limit
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    arb_state_t        state_q, state_d;
    req_id_t           grant_q, grant_d;
    req_id_t           last_grant_q, last_grant_d;
    logic              rr_valid_c;
    req_id_t           rr_grant_c;

    logic              mov_d, rw_d, if_done_d, d_done_d, busy_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, if_rdata_d, d_rdata_d;
    logic [OPC_W-1:0]  opc_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              err_d;
`endif

    mem_arb_rr u_rr (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .valid_c    (rr_valid_c),
        .grant_c    (rr_grant_c)
    );

    // next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mov_d        = mem_mov;
        rw_d         = mem_rw;
        addr_d       = mem_addr;
        wdata_d      = mem_wdata;
        opc_d        = mem_opc;
        if_rdata_d   = if_rdata;
        d_rdata_d    = d_rdata;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
        err_d        = err;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // stale MOC here is deliberately ignored
                if (rr_valid_c) begin
                    grant_d = rr_grant_c;
                    if (rr_grant_c == REQ_IF) begin
                        rw_d    = RW_READ;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        opc_d   = IF_OPC;
                    end else begin
                        rw_d    = d_rw;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        opc_d   = d_opc;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mov_d   = 1'b1;
                state_d = ST_WAIT_MOC;
`ifdef MEM_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            ST_WAIT_MOC: begin
                if (mem_moc) begin
                    if (mem_rw != RW_WRITE) begin
                        if (grant_q == REQ_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    mov_d   = 1'b0;
                    state_d = ST_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // give up: complete without data and flag the error
                    mov_d        = 1'b0;
                    if_done_d    = (grant_q == REQ_IF);
                    d_done_d     = (grant_q == REQ_D);
                    last_grant_d = grant_q;
                    err_d        = 1'b1;
                    state_d      = ST_RELEASE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: begin
                if_done_d    = (grant_q == REQ_IF);
                d_done_d     = (grant_q == REQ_D);
                last_grant_d = grant_q;
                state_d      = ST_RELEASE;
            end
            ST_RELEASE: begin
                // RAM must deassert MOC before the next transaction
                if (!mem_moc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mov_d   = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= REQ_IF;
            last_grant_q <= REQ_D;
            mem_mov      <= 1'b0;
            mem_rw       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_opc      <= '0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            busy         <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wd_cnt_q     <= '0;
            err          <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_mov      <= mov_d;
            mem_rw       <= rw_d;
            mem_addr     <= addr_d;
            mem_wdata    <= wdata_d;
            mem_opc      <= opc_d;
            if_rdata     <= if_rdata_d;
            d_rdata      <= d_rdata_d;
            if_done      <= if_done_d;
            d_done       <= d_done_d;
            busy         <= busy_d;
`ifdef MEM_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
            err          <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a word-array RAM responder,
// a round-robin grant model and expected read-data registers.
// Define MEM_TIMEOUT_EN to also exercise the MOC watchdog.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 6;

    logic              clk, reset;
    logic              if_req, d_req, d_rw, mem_moc;
    logic [ADDR_W-1:0] if_addr, d_addr;
    logic [DATA_W-1:0] d_wdata, mem_rdata;
    logic [OPC_W-1:0]  d_opc;
    logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata;
    logic              if_done, d_done, mem_mov, mem_rw, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [OPC_W-1:0]  mem_opc;
`ifdef MEM_TIMEOUT_EN
    logic              err;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] ram [512];
    logic [DATA_W-1:0] exp_if_rdata, exp_d_rdata;
    req_id_t           last_m;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_opc     (d_opc),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_mov   (mem_mov),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_opc   (mem_opc),
        .mem_rdata (mem_rdata),
        .mem_moc   (mem_moc),
`ifdef MEM_TIMEOUT_EN
        .busy      (busy),
        .err       (err)
`else
        .busy      (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Round-robin rule: alone wins; on a tie the one not served last wins.
    function automatic req_id_t pick(input logic ir, input logic dr, input req_id_t last);
        if (ir && dr) return (last == REQ_IF) ? REQ_D : REQ_IF;
        return ir ? REQ_IF : REQ_D;
    endfunction

    // Plays the RAM side of one transaction granted to gid and checks it.
    task automatic serve(input req_id_t gid, input int delay, input int hold, input bit keep);
        logic [ADDR_W-1:0] ea;
        logic              erw;
        logic [DATA_W-1:0] ewd;
        logic [OPC_W-1:0]  eop;
        bit                ok;
        int                w;
        if (gid == REQ_IF) begin
            ea = if_addr; erw = 1'b1; ewd = '0; eop = 6'b100011;
        end else begin
            ea = d_addr; erw = d_rw; ewd = d_wdata; eop = d_opc;
        end
        w = 0;
        while (mem_mov !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (mem_mov !== 1'b1) begin
            miscompares++;
            $display("FAIL mov_rise: mem_mov=%b after %0d cycles, expected 1", mem_mov, w);
            return;
        end
        vectors++;
        if ({mem_addr, mem_rw, mem_wdata, mem_opc} !== {ea, erw, ewd, eop}) begin
            miscompares++;
            $display("FAIL payload: got addr=%h rw=%b wdata=%h opc=%b, expected addr=%h rw=%b wdata=%h opc=%b",
                     mem_addr, mem_rw, mem_wdata, mem_opc, ea, erw, ewd, eop);
        end
        if (erw) mem_rdata = ram[ea];
        ok = 1'b1;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (mem_mov !== 1'b1 || {mem_addr, mem_rw, mem_wdata, mem_opc} !== {ea, erw, ewd, eop}
                || if_done !== 1'b0 || d_done !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL hold_stable: mem_* changed or done early while waiting for MOC (mov=%b addr=%h)",
                     mem_mov, mem_addr);
        end
        mem_moc = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_mov !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mov_drop: mov=%b if_done=%b d_done=%b, expected 0 0 0", mem_mov, if_done, d_done);
        end
        @(negedge clk);
        if (gid == REQ_IF) exp_if_rdata = ram[ea];
        else if (erw) exp_d_rdata = ram[ea];
        else ram[ea] = ewd;
        last_m = gid;
        vectors++;
        if (if_done !== 1'(gid == REQ_IF) || d_done !== 1'(gid == REQ_D)) begin
            miscompares++;
            $display("FAIL done: if_done=%b d_done=%b, expected grant %s", if_done, d_done, gid.name());
        end
        vectors++;
        if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata) begin
            miscompares++;
            $display("FAIL rdata: if_rdata=%h d_rdata=%h, expected %h %h",
                     if_rdata, d_rdata, exp_if_rdata, exp_d_rdata);
        end
        if (!keep) begin
            if (gid == REQ_IF) if_req = 1'b0;
            else d_req = 1'b0;
        end
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (mem_mov !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL release_hold: left RELEASE or extra done while MOC high (mov=%b busy=%b)",
                     mem_mov, busy);
        end
        mem_moc   = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        vectors++;
        if (mem_mov !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL release_exit: mov=%b if_done=%b d_done=%b busy=%b, expected 0 0 0 0",
                     mem_mov, if_done, d_done, busy);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        if_addr = 9'h1A0;
        d_rw    = 1'b1;
        d_addr  = 9'h0C4;
        d_wdata = 32'h1234_5678;
        d_opc   = 6'b100000;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mem_mov, mem_rw, mem_addr, mem_wdata, mem_opc, if_rdata, d_rdata, if_done, d_done, busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: mov=%b rw=%b addr=%h wdata=%h opc=%b if_rdata=%h d_rdata=%h busy=%b, expected all 0",
                     mem_mov, mem_rw, mem_addr, mem_wdata, mem_opc, if_rdata, d_rdata, busy);
        end
        reset = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        last_m       = REQ_D;
        serve(pick(if_req, d_req, last_m), 2, 0, 1'b0);
        serve(pick(if_req, d_req, last_m), 1, 1, 1'b0);
    endtask

    task automatic test_stale_moc();
        bit ok = 1'b1;
        mem_moc = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || mem_mov !== 1'b0 || if_done !== 1'b0 || d_done !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stale_moc: busy=%b mov=%b if_done=%b d_done=%b, expected idle", busy, mem_mov, if_done, d_done);
        end
        mem_moc = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        ram[9'h004] = 32'h8C22_0000;
        if_addr = 9'h004;
        if_req  = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_mov !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_latency: mov=%b busy=%b one cycle after sample, expected 0 1", mem_mov, busy);
        end
        serve(REQ_IF, 3, 0, 1'b0);
        vectors++;
        if (if_rdata !== 32'h8C22_0000) begin
            miscompares++;
            $display("FAIL fetch_word: if_rdata=%h, expected 8c220000", if_rdata);
        end
    endtask

    task automatic test_store();
        d_rw    = 1'b0;
        d_addr  = 9'h010;
        d_wdata = 32'hDEAD_BEEF;
        d_opc   = 6'b101011;
        d_req   = 1'b1;
        serve(REQ_D, 4, 0, 1'b0);
    endtask

    task automatic test_contention();
        if_addr = 9'($urandom);
        d_rw    = 1'($urandom_range(0, 1));
        d_addr  = 9'($urandom);
        d_wdata = $urandom;
        d_opc   = 6'($urandom);
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_id_t g = pick(if_req, d_req, last_m);
            serve(g, $urandom_range(0, 3), 0, 1'b1);
            if (g == REQ_IF) begin
                if_addr = 9'($urandom);
            end else begin
                d_rw    = 1'($urandom_range(0, 1));
                d_addr  = 9'($urandom);
                d_wdata = $urandom;
                d_opc   = 6'($urandom);
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_moc_hold();
        if_addr = 9'($urandom);
        d_rw    = 1'b1;
        d_addr  = 9'($urandom);
        d_opc   = 6'b100011;
        if_req  = 1'b1;
        d_req   = 1'b1;
        serve(pick(if_req, d_req, last_m), 1, 5, 1'b0);
        serve(pick(if_req, d_req, last_m), 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_addr = 9'($urandom);
                if_req  = 1'b1;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_rw    = 1'($urandom_range(0, 1));
                d_addr  = 9'($urandom);
                d_wdata = $urandom;
                d_opc   = 6'($urandom);
                d_req   = 1'b1;
            end
            if (!if_req && !d_req) begin
                if_addr = 9'($urandom);
                if_req  = 1'b1;
            end
            serve(pick(if_req, d_req, last_m), $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
        end
        if (if_req || d_req) serve(pick(if_req, d_req, last_m), 1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b1;
        int w = 0;
        d_rw    = 1'b0;
        d_addr  = 9'h1F0;
        d_wdata = $urandom;
        d_opc   = 6'b101011;
        d_req   = 1'b1;
        while (mem_mov !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (mem_mov !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: mov=%b busy=%b right after reset, expected 0 0", mem_mov, busy);
        end
        d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (if_done !== 1'b0 || d_done !== 1'b0 || mem_mov !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reset_mid_done: done pulse or MOV after abandoned transaction (d_done=%b)", d_done);
        end
        reset = 1'b1;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        last_m       = REQ_D;
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int  w = 0;
        int  cnt = 0;
        bit  ok = 1'b1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_init: err=%b, expected 0", err);
        end
        if_addr = 9'($urandom);
        if_req  = 1'b1;
        while (mem_mov !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        while (mem_mov === 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        vectors++;
        if (cnt != 16 || if_done !== 1'b1 || d_done !== 1'b0 || err !== 1'b1 || if_rdata !== exp_if_rdata) begin
            miscompares++;
            $display("FAIL timeout: mov cycles=%0d if_done=%b err=%b if_rdata=%h, expected 16 1 1 %h",
                     cnt, if_done, err, if_rdata, exp_if_rdata);
        end
        if_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (err !== 1'b1 || if_done !== 1'b0 || mem_mov !== 1'b0) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b if_done=%b, expected 1 0", err, if_done);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_reset: err=%b, expected 0", err);
        end
        @(negedge clk);
        reset  = 1'b1;
        last_m = REQ_D;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        @(negedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = $urandom;
        reset     = 1'b0;
        if_req    = 1'b0;
        d_req     = 1'b0;
        d_rw      = 1'b0;
        if_addr   = '0;
        d_addr    = '0;
        d_wdata   = '0;
        d_opc     = '0;
        mem_moc   = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_stale_moc();
        test_single_fetch();
        test_store();
        test_contention();
        test_moc_hold();
        test_random();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single ram512x8 port (MOV/MOC/RW handshake) between the instruction-fetch path and the load/store path of the MIPS datapath.
- Accepts one request per requester and arbitrates between them round-robin.
- Drives the memory handshake, waits for MOC, returns read data and a one-cycle done pulse to the requester that was granted.
- Sits between the DataPath control unit and the RAM model, replacing the direct MOV/RW/MAR/OpC wiring.

Parameters:
- ADDR_W, 9, memory byte-address width (MAR[8:0]).
- DATA_W, 32, data bus width.
- OPC_W, 6, opcode width forwarded to the RAM for byte/half/word sizing.
- IF_OPC, 6'b100011, fixed opcode driven for fetches (lw, word access).
- TIMEOUT_CYCLES, 16, MOC watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, level.
- d_rw  in  1  1=read (load), 0=write (store).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_opc  in  OPC_W  load/store opcode.
- d_rdata  out  DATA_W  load data.
- d_done  out  1  one-cycle completion pulse for data.
- mem_mov  out  1  MOV to RAM.
- mem_rw  out  1  RW to RAM (1=read).
- mem_addr  out  ADDR_W  MAR to RAM.
- mem_wdata  out  DATA_W  DataIn to RAM.
- mem_opc  out  OPC_W  OpC to RAM.
- mem_rdata  in  DATA_W  DataOut from RAM.
- mem_moc  in  1  MOC from RAM.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; last_grant=DATA.
  - All outputs are 0: mem_mov, mem_rw, mem_addr, mem_wdata, mem_opc, if_rdata, d_rdata, if_done, d_done, busy.
- FSM states: IDLE -> ISSUE -> WAIT_MOC -> DONE -> RELEASE -> IDLE.
- IDLE: sample if_req and d_req.
  - Only one asserted: grant it.
  - Both asserted: grant the requester that is not last_grant (round-robin). The first tie after reset goes to fetch.
  - Latch address, rw, wdata and opc into the output registers. Fetch forces rw=1, opc=IF_OPC and wdata=0.
  - Go to ISSUE.
- ISSUE: drive mem_mov=1 with the latched signals; go to WAIT_MOC. MOV therefore rises 1 cycle after the IDLE sample edge.
- WAIT_MOC:
  - Hold mem_mov and all mem_* signals stable.
  - When mem_moc=1 is sampled:
    - on a read, capture mem_rdata into the granted requester's rdata register;
    - drop mem_mov;
    - go to DONE.
- DONE:
  - Pulse the granted requester's done signal for exactly 1 cycle; update last_grant.
  - rdata stays valid from this cycle until that requester's next read completes.
  - Go to RELEASE.
- RELEASE: wait until mem_moc=0, then go to IDLE. Any number of cycles is allowed.
- Requester rule:
  - Hold req and its inputs stable until done is seen.
  - Drop req in the cycle done is sampled high.
  - The arbiter does not resample requests until IDLE, which is at least 1 cycle after done.
- Writes: d_rdata is unchanged; d_done still pulses.
- Latency: request sampled at edge N gives MOV high from N+1. MOC sampled at edge M gives done high in cycle M+1.
- mem_moc=1 while in IDLE (stale): ignored. It is not treated as a completion.
- Reset asserted mid-transaction: the transaction is abandoned, mem_mov drops immediately, and no done pulse is produced.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - Adds output port err (1 bit, reset 0) and a watchdog counter, cleared on entry to WAIT_MOC.
  - If mem_moc stays 0 for TIMEOUT_CYCLES cycles in WAIT_MOC:
    - drop mem_mov;
    - pulse the requester's done with its rdata unchanged;
    - set err=1 (sticky until reset);
    - go to RELEASE.
- When undefined: no err port and no counter; WAIT_MOC waits indefinitely.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encodings (IDLE=0, ISSUE=1, WAIT_MOC=2, DONE=3, RELEASE=4, 3-bit);
  - requester IDs (REQ_IF=0, REQ_D=1);
  - RW_READ=1 and RW_WRITE=0;
  - the default IF_OPC.
- Natural sub-module: mem_arb_rr, a 2-way round-robin pick from (if_req, d_req, last_grant) to a grant ID. It is combinational, with the last_grant register kept in the parent.

Test Plan:
- Reset: hold reset=0 with both reqs high -> all outputs 0 and busy=0. Release reset -> fetch granted, mem_opc=6'b100011.
- Single fetch: if_addr=9'h004, RAM word 32'h8C220000, MOC 3 cycles after MOV -> mem_addr=9'h004, mem_rw=1, if_rdata=32'h8C220000, if_done pulses once, d_done stays 0.
- Store: d_rw=0, d_addr=9'h010, d_wdata=32'hDEADBEEF, d_opc=6'b101011 -> mem_rw=0 and mem_wdata=32'hDEADBEEF for the whole MOV period; d_done pulse; d_rdata unchanged.
- Contention: both reqs held for 4 transactions -> grant order IF, D, IF, D.
- MOC held high 5 extra cycles after MOV drops -> stays in RELEASE; no second done; next grant only after MOC=0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=16 and MOC never asserted -> MOV drops after 16 cycles in WAIT_MOC; done pulse; err=1 until reset.
